issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, minimum 4.
REQ-002 Parameter PAYLOAD_W, default 96, opaque per-instruction payload width.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 flush  in  1  synchronous pipeline flush.
REQ-006 in_valid  in  2  decode-side valids; bit0 is the older slot; legal values 00, 01, 11 only.
REQ-007 in_payload  in  2xPAYLOAD_W  per-slot payload.
REQ-008 in_dst  in  2x5  per-slot destination GPR; 0 means no write.
REQ-009 in_src  in  2x10  per-slot {rt, rs} source GPRs; 0 means unused.
REQ-010 in_is_mem, in_is_branch  in  2 each  per-slot attributes.
REQ-011 allowin_I  out  1  high when at least 2 entries are free.
REQ-012 issue_ready  in  1  backend accepts the whole issue group this cycle.
REQ-013 issue_valid  out  2  bit0 = head, bit1 = head+1; value 10 is never driven.
REQ-014 issue_payload  out  2xPAYLOAD_W  payloads of head and head+1.

Function
REQ-015 The block is a circular in-order FIFO with a head pointer, a tail pointer (log2 DEPTH bits, wrap modulo DEPTH) and a count (0..DEPTH).
REQ-016 allowin_I SHALL be (DEPTH - count) >= 2, computed from registered count only, with no same-cycle dequeue bypass.
REQ-017 Enqueue occurs when allowin_I is high and in_valid != 00; 01 writes slot0 at tail; 11 writes slot0 at tail and slot1 at tail+1.
REQ-018 Input presented while allowin_I is low SHALL be ignored.
REQ-019 Slot0 eligibility: count >= 1, and the head is not a branch with count < 2; a branch waits for its delay slot.
REQ-020 Slot1 eligibility: slot0 eligible, count >= 2, and head+1 is not a branch.
REQ-021 Slot1 is further blocked by a RAW hazard: head.dst != 0 and head.dst equals either nonzero source of head+1.
REQ-022 Slot1 is further blocked when head and head+1 are both is_mem, because there is a single LSU.
REQ-023 issue_valid is combinational from queue state: {slot1_eligible, slot0_eligible}, forced to 00 while flush is high.
REQ-024 Dequeue of popcount(issue_valid) entries occurs only when issue_ready is high; with issue_ready low, outputs hold and state is unchanged.
REQ-025 On simultaneous enqueue and dequeue, count_next = count + enq_n - deq_n; a full queue with dequeue in the same cycle still refuses input.
REQ-026 A branch issued alone in slot0 (its delay slot is blocked) is legal; the delay slot issues in a later cycle.
REQ-027 flush has priority over enqueue and dequeue: next cycle count = 0 and head = tail = 0, and entry storage is not cleared.
REQ-028 Latency: an entry enqueued at edge N can issue no earlier than the cycle following edge N, with no bypass from the input.

Reset
REQ-029 With resetn low: count = 0, head = tail = 0, issue_valid = 00, allowin_I = 1.
REQ-030 Reset asserted mid-operation discards all entries immediately, regardless of clk.
REQ-031 Payload storage is not reset; its contents are don't-care while the queue is empty.

Verification
REQ-032 Enqueue 11 with A(dst=5) and B(src rs=5), issue_ready=1 -> cycle 1 issue_valid=01 (A); cycle 2 issue_valid=01 (B).
REQ-033 Enqueue 01 with a branch J, hold input idle 3 cycles, then enqueue delay slot D (independent) -> issue_valid=00 while J is alone; after D arrives, issue_valid=11 with {D, J}.
REQ-034 DEPTH=8: fill with 4 enqueues of 11 with issue_ready=0 -> allowin_I=0 and count=8; set issue_ready=1 with two independent ALU ops at the head -> count=6 next cycle and allowin_I=1.
REQ-035 Head load plus load at head+1 -> issue_valid=01; independent load plus ALU -> issue_valid=11.
REQ-036 Queue holds 5 entries; assert flush together with enqueue 11 and issue_ready=1 -> issue_valid=00 in the flush cycle; next cycle count=0 and allowin_I=1.
REQ-037 Wrap-around: run 20 cycles of enqueue 11 and dual issue with pointers crossing DEPTH -> issue order equals enqueue order, with no loss and no duplication.

Source files
------------

// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order dual-issue queue between decode and execute.
// Holds up to DEPTH entries and issues head / head+1 subject to hazards.
module issue_scheduler #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 96
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [2*PAYLOAD_W-1:0] in_payload,
  input  logic [9:0]             in_dst,
  input  logic [19:0]            in_src,
  input  logic [1:0]             in_is_mem,
  input  logic [1:0]             in_is_branch,
  output logic                   allowin_I,
  input  logic                   issue_ready,
  output logic [1:0]             issue_valid,
  output logic [2*PAYLOAD_W-1:0] issue_payload
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PAYLOAD_W-1:0] r_pl  [DEPTH];
  logic [4:0]           r_dst [DEPTH];
  logic [4:0]           r_rs  [DEPTH];
  logic [4:0]           r_rt  [DEPTH];
  logic                 r_mem [DEPTH];
  logic                 r_br  [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_h1;
  logic [AW-1:0] w_t1;
  logic [CW-1:0] w_free;
  logic          w_enq;
  logic [1:0]    w_enq_n;
  logic [1:0]    w_deq_n;
  logic          w_s0;
  logic          w_s1;
  logic          w_raw;
  logic          w_lsu;

  assign w_h1   = r_head + AW'(1);
  assign w_t1   = r_tail + AW'(1);
  assign w_free = CW'(DEPTH) - r_count;

  assign allowin_I = (w_free >= CW'(2));
  assign w_enq     = allowin_I && (in_valid != 2'b00);
  assign w_enq_n   = !w_enq ? 2'd0 : (in_valid[1] ? 2'd2 : 2'd1);

  // A nonzero head.dst equal to a source implies that source is nonzero.
  assign w_raw = (r_dst[r_head] != 5'd0) &&
                 ((r_rs[w_h1] == r_dst[r_head]) ||
                  (r_rt[w_h1] == r_dst[r_head]));
  assign w_lsu = r_mem[r_head] && r_mem[w_h1];

  // A lone branch waits for its delay slot to arrive.
  assign w_s0 = (r_count != '0) &&
                !(r_br[r_head] && (r_count < CW'(2)));

  assign w_s1 = w_s0 && (r_count >= CW'(2)) &&
                !r_br[w_h1] && !w_raw && !w_lsu;

  assign issue_valid = flush ? 2'b00 : {w_s1, w_s0};

  assign w_deq_n = !issue_ready ? 2'd0 :
                   ({1'b0, issue_valid[0]} + {1'b0, issue_valid[1]});

  assign issue_payload = {r_pl[w_h1], r_pl[r_head]};

  // Pointer and occupancy update; flush wins over enqueue and dequeue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_deq_n);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
    end
  end

  // Entry storage is never reset; stale contents are unreachable.
  always_ff @(posedge clk) begin
    if (w_enq && !flush) begin
      r_pl[r_tail]  <= in_payload[PAYLOAD_W-1:0];
      r_dst[r_tail] <= in_dst[4:0];
      r_rs[r_tail]  <= in_src[4:0];
      r_rt[r_tail]  <= in_src[9:5];
      r_mem[r_tail] <= in_is_mem[0];
      r_br[r_tail]  <= in_is_branch[0];
      if (in_valid[1]) begin
        r_pl[w_t1]  <= in_payload[2*PAYLOAD_W-1:PAYLOAD_W];
        r_dst[w_t1] <= in_dst[9:5];
        r_rs[w_t1]  <= in_src[14:10];
        r_rt[w_t1]  <= in_src[19:15];
        r_mem[w_t1] <= in_is_mem[1];
        r_br[w_t1]  <= in_is_branch[1];
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model.
module tb_issue_scheduler;

  localparam int DEPTH = 8;
  localparam int PW    = 96;

  typedef struct packed {
    logic [PW-1:0] pl;
    logic [4:0]    dst;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          mem;
    logic          br;
  } ent_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic [1:0]    in_valid;
  logic [2*PW-1:0] in_payload;
  logic [9:0]    in_dst;
  logic [19:0]   in_src;
  logic [1:0]    in_is_mem;
  logic [1:0]    in_is_branch;
  logic          allowin_I;
  logic          issue_ready;
  logic [1:0]    issue_valid;
  logic [2*PW-1:0] issue_payload;

  issue_scheduler #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload),
    .in_dst(in_dst), .in_src(in_src),
    .in_is_mem(in_is_mem), .in_is_branch(in_is_branch),
    .allowin_I(allowin_I), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_payload(issue_payload)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   tag = 0;
  int   issued = 0;
  logic [1:0] obs_iv;
  logic       obs_allow;
  logic [PW-1:0] obs_pl0;
  logic [PW-1:0] obs_pl1;
  ent_t idle;

  task automatic chk(input string nm, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic ent_t mk(input int dst, input int rs, input int rt,
                              input bit mem, input bit br);
    ent_t e;
    tag++;
    e.pl  = {32'(tag), $urandom(), $urandom()};
    e.dst = 5'(dst);
    e.rs  = 5'(rs);
    e.rt  = 5'(rt);
    e.mem = mem;
    e.br  = br;
    return e;
  endfunction

  function automatic ent_t rnd();
    return mk($urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 6), $urandom_range(0, 2) == 0,
              $urandom_range(0, 4) == 0);
  endfunction

  function automatic bit raw(input ent_t h, input ent_t n);
    return h.dst != 0 && ((n.rs != 0 && n.rs == h.dst) ||
                          (n.rt != 0 && n.rt == h.dst));
  endfunction

  // One cycle: drive at negedge, compare, advance model, wait next negedge.
  task automatic step(input logic [1:0] v, input ent_t a, input ent_t b,
                      input logic fl, input logic rdy);
    bit       allow;
    bit       e0;
    bit       e1;
    logic [1:0] eiv;
    int       n;
    in_valid     = v;
    in_payload   = {b.pl, a.pl};
    in_dst       = {b.dst, a.dst};
    in_src       = {b.rt, b.rs, a.rt, a.rs};
    in_is_mem    = {b.mem, a.mem};
    in_is_branch = {b.br, a.br};
    flush        = fl;
    issue_ready  = rdy;
    #1;
    allow = (DEPTH - q.size()) >= 2;
    e0 = q.size() >= 1 && !(q.size() < 2 && q[0].br);
    e1 = 0;
    if (e0 && q.size() >= 2)
      e1 = !q[1].br && !raw(q[0], q[1]) && !(q[0].mem && q[1].mem);
    eiv = fl ? 2'b00 : {e1, e0};
    obs_iv    = issue_valid;
    obs_allow = allowin_I;
    obs_pl0   = issue_payload[PW-1:0];
    obs_pl1   = issue_payload[2*PW-1:PW];
    chk("allowin", PW'(allowin_I), PW'(allow));
    chk("issue_valid", PW'(issue_valid), PW'(eiv));
    if (eiv[0]) chk("payload0", obs_pl0, q[0].pl);
    if (eiv[1]) chk("payload1", obs_pl1, q[1].pl);
    if (rdy && !fl) issued += int'(obs_iv[0]) + int'(obs_iv[1]);
    if (fl) begin
      q.delete();
    end else begin
      n = rdy ? int'(eiv[0]) + int'(eiv[1]) : 0;
      repeat (n) void'(q.pop_front());
      if (allow && v != 2'b00) begin
        q.push_back(a);
        if (v[1]) q.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset taken between clock edges.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_issue_valid", PW'(issue_valid), PW'(2'b00));
    chk("rst_allowin", PW'(allowin_I), PW'(1'b1));
    q.delete();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic idle_steps(input int n);
    repeat (n) step(2'b00, idle, idle, 1'b0, 1'b1);
  endtask

  initial begin
    ent_t a;
    ent_t b;
    idle = '0;
    resetn = 1'b0;
    flush = 1'b0;
    in_valid = 2'b00;
    in_payload = '0;
    in_dst = '0;
    in_src = '0;
    in_is_mem = '0;
    in_is_branch = '0;
    issue_ready = 1'b0;
    #3;
    chk("reset_issue_valid", PW'(issue_valid), PW'(2'b00));
    chk("reset_allowin", PW'(allowin_I), PW'(1'b1));
    @(negedge clk);
    resetn = 1'b1;

    // RAW pair issues one at a time
    a = mk(5, 0, 0, 0, 0);
    b = mk(7, 5, 0, 0, 0);
    step(2'b11, a, b, 1'b0, 1'b1);
    idle_steps(1);
    chk("raw_c1_iv", PW'(obs_iv), PW'(2'b01));
    chk("raw_c1_pl", obs_pl0, a.pl);
    idle_steps(1);
    chk("raw_c2_iv", PW'(obs_iv), PW'(2'b01));
    chk("raw_c2_pl", obs_pl0, b.pl);
    idle_steps(1);

    // Branch waits for delay slot
    a = mk(0, 3, 0, 0, 1);
    step(2'b01, a, idle, 1'b0, 1'b1);
    idle_steps(3);
    chk("branch_alone_iv", PW'(obs_iv), PW'(2'b00));
    b = mk(9, 1, 2, 0, 0);
    step(2'b01, b, idle, 1'b0, 1'b1);
    chk("branch_ds_arrive_iv", PW'(obs_iv), PW'(2'b00));
    idle_steps(1);
    chk("branch_pair_iv", PW'(obs_iv), PW'(2'b11));
    chk("branch_pair_j", obs_pl0, a.pl);
    chk("branch_pair_d", obs_pl1, b.pl);
    idle_steps(1);

    // Fill to full, then dequeue with input refused
    for (int i = 0; i < 4; i++)
      step(2'b11, mk(2*i+1, 0, 0, 0, 0), mk(2*i+2, 0, 0, 0, 0),
           1'b0, 1'b0);
    step(2'b11, mk(20, 0, 0, 0, 0), mk(21, 0, 0, 0, 0), 1'b0, 1'b1);
    chk("full_allowin", PW'(obs_allow), PW'(1'b0));
    chk("full_iv", PW'(obs_iv), PW'(2'b11));
    idle_steps(1);
    chk("after_full_allowin", PW'(obs_allow), PW'(1'b1));
    idle_steps(4);

    // Single LSU
    step(2'b11, mk(1, 0, 0, 1, 0), mk(2, 0, 0, 1, 0), 1'b0, 1'b1);
    idle_steps(1);
    chk("two_loads_iv", PW'(obs_iv), PW'(2'b01));
    idle_steps(1);
    step(2'b11, mk(3, 0, 0, 1, 0), mk(4, 0, 0, 0, 0), 1'b0, 1'b1);
    idle_steps(1);
    chk("load_alu_iv", PW'(obs_iv), PW'(2'b11));

    // Flush with 5 entries and concurrent enqueue
    step(2'b11, mk(1, 0, 0, 0, 0), mk(2, 0, 0, 0, 0), 1'b0, 1'b0);
    step(2'b11, mk(3, 0, 0, 0, 0), mk(4, 0, 0, 0, 0), 1'b0, 1'b0);
    step(2'b01, mk(5, 0, 0, 0, 0), idle, 1'b0, 1'b0);
    step(2'b11, mk(6, 0, 0, 0, 0), mk(7, 0, 0, 0, 0), 1'b1, 1'b1);
    chk("flush_iv", PW'(obs_iv), PW'(2'b00));
    idle_steps(1);
    chk("post_flush_allowin", PW'(obs_allow), PW'(1'b1));
    chk("post_flush_iv", PW'(obs_iv), PW'(2'b00));

    // Wrap-around streaming
    issued = 0;
    repeat (20)
      step(2'b11, mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 1'b0, 1'b1);
    idle_steps(1);
    chk("wrap_issued", PW'(issued), PW'(40));

    // Random traffic with occasional flush and async reset
    for (int i = 0; i < 600; i++) begin
      logic [1:0] v;
      case ($urandom_range(0, 2))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      if ($urandom_range(0, 59) == 0) do_reset();
      else step(v, rnd(), rnd(), $urandom_range(0, 39) == 0,
                $urandom_range(0, 9) < 7);
    end
    idle_steps(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
